// File: rtl/z80_bus_pkg.sv
// Shared types and helpers for the Z80-style bus-cycle engine.
package z80_bus_pkg;

    localparam int unsigned WaitW = 3;

    typedef enum logic [2:0] {
        KindMemRd = 3'd0,
        KindMemWr = 3'd1,
        KindIoRd  = 3'd2,
        KindIoWr  = 3'd3,
        KindFetch = 3'd4
    } bus_kind_t;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StTw,
        StT3,
        StT4
    } tstate_t;

    typedef struct packed {
        logic n_mreq;
        logic n_iorq;
        logic n_rd;
        logic n_wr;
        logic n_m1;
        logic n_rfsh;
    } strobes_t;

    localparam strobes_t StrobesOff = strobes_t'(6'h3f);

    function automatic logic is_io(bus_kind_t k);
        return (k == KindIoRd) || (k == KindIoWr);
    endfunction

    function automatic logic is_write(bus_kind_t k);
        return (k == KindMemWr) || (k == KindIoWr);
    endfunction

    function automatic logic is_legal(logic [2:0] k);
        return k <= 3'd4;
    endfunction

    // Request/direction strobes of the access part of a cycle; nM1 and nRFSH stay high.
    function automatic strobes_t access_strobes(bus_kind_t k);
        strobes_t s;
        s        = StrobesOff;
        s.n_mreq = is_io(k);
        s.n_iorq = !is_io(k);
        s.n_rd   = is_write(k);
        s.n_wr   = !is_write(k);
        return s;
    endfunction

endpackage

// File: rtl/z80_wait_ctr.sv
// Mandatory wait-state counter; combines the remaining count with nWAIT into stay_in_tw.
module z80_wait_ctr
    import z80_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WaitW-1:0] load_val,
    input  logic             count_en,
    input  logic             nWAIT,
    output logic             stay_in_tw
);

    logic [WaitW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (count_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Mandatory waits take priority; nWAIT only matters once the count is exhausted.
    assign stay_in_tw = (cnt_q != '0) || !nWAIT;

endmodule

// File: rtl/z80_bus_cycle.sv
// Bus-cycle engine: turns sequencer requests into Z80-style T-state sequences on registered pins.
module z80_bus_cycle
    import z80_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MEM_WAIT   = 0,
    parameter int unsigned IO_WAIT    = 1,
    parameter int unsigned REFRESH_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [2:0]        kind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] rfsh_addr,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    input  logic              nWAIT,
    input  logic [DATA_W-1:0] READ_D,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] WRITE_D,
    output logic              bus_oe,
    output logic              nMREQ,
    output logic              nIORQ,
    output logic              nRD,
    output logic              nWR,
    output logic              nM1,
    output logic              nRFSH
);

    if (MEM_WAIT + IO_WAIT > 7) begin : g_wait_range
        $error("MEM_WAIT + IO_WAIT must not exceed 7");
    end

    localparam logic [WaitW-1:0] MemWaitLd = WaitW'(MEM_WAIT);
    localparam logic [WaitW-1:0] IoWaitLd  = WaitW'(MEM_WAIT + IO_WAIT);
    localparam bit               RfshOn    = (REFRESH_EN != 0);

    tstate_t           state_q, state_d;
    bus_kind_t         kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              oe_q, oe_d;
    strobes_t          strb_q, strb_d;

    logic              last_t;
    logic              accept;
    logic              ctr_load;
    logic [WaitW-1:0]  ctr_load_val;
    logic              stay_in_tw;
    bus_kind_t         req_kind;
    logic              fetch_rfsh_d;

    assign req_kind = bus_kind_t'(kind);
    assign last_t   = ((state_q == StT3) && !((kind_q == KindFetch) && RfshOn)) ||
                      (state_q == StT4);
    assign ready    = (state_q == StIdle) || last_t;
    assign accept   = req && ready && is_legal(kind);

    assign ctr_load     = accept;
    assign ctr_load_val = is_io(req_kind) ? IoWaitLd : MemWaitLd;

    z80_wait_ctr u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (ctr_load),
        .load_val   (ctr_load_val),
        .count_en   ((state_q == StT2) || (state_q == StTw)),
        .nWAIT      (nWAIT),
        .stay_in_tw (stay_in_tw)
    );

    // Next T-state, latched request and read capture.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: ;
            StT1:   state_d = StT2;
            StT2, StTw: begin
                if (stay_in_tw) begin
                    state_d = StTw;
                end else begin
                    state_d = StT3;
                    if (kind_q == KindFetch) begin
                        rdata_d = READ_D;
                    end
                end
            end
            StT3: begin
                if ((kind_q == KindFetch) && RfshOn) begin
                    state_d = StT4;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (!is_write(kind_q) && (kind_q != KindFetch)) begin
                        rdata_d = READ_D;
                    end
                end
            end
            StT4: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d = StT1;
            kind_d  = req_kind;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
    end

    assign fetch_rfsh_d = (kind_d == KindFetch) && RfshOn;

    // Pin values for the upcoming T-state, registered so the pins are glitch-free.
    always_comb begin
        strb_d = StrobesOff;
        a_d    = a_q;
        wd_d   = wd_q;
        oe_d   = 1'b0;

        case (state_d)
            StIdle: ;
            StT1: begin
                a_d        = addr_d;
                strb_d.n_m1 = (kind_d != KindFetch);
            end
            StT2, StTw: begin
                a_d         = addr_d;
                strb_d      = access_strobes(kind_d);
                strb_d.n_m1 = (kind_d != KindFetch);
            end
            StT3: begin
                if (fetch_rfsh_d) begin
                    a_d           = rfsh_addr;
                    strb_d.n_mreq = 1'b0;
                    strb_d.n_rfsh = 1'b0;
                end else begin
                    a_d    = addr_d;
                    strb_d = access_strobes(kind_d);
                end
            end
            StT4: begin
                a_d           = rfsh_addr;
                strb_d.n_rfsh = 1'b0;
            end
            default: ;
        endcase

        if ((state_d == StT1 || state_d == StT2 || state_d == StTw || state_d == StT3) &&
            is_write(kind_d)) begin
            wd_d = wdata_d;
            oe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            kind_q  <= KindMemRd;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            oe_q    <= 1'b0;
            strb_q  <= StrobesOff;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            oe_q    <= oe_d;
            strb_q  <= strb_d;
        end
    end

    assign done    = done_q;
    assign rdata   = rdata_q;
    assign A       = a_q;
    assign WRITE_D = wd_q;
    assign bus_oe  = oe_q;
    assign nMREQ   = strb_q.n_mreq;
    assign nIORQ   = strb_q.n_iorq;
    assign nRD     = strb_q.n_rd;
    assign nWR     = strb_q.n_wr;
    assign nM1     = strb_q.n_m1;
    assign nRFSH   = strb_q.n_rfsh;

endmodule

// File: doc/z80_bus_cycle.md
Name: z80_bus_cycle

Overview:
- Parametrised bus-cycle engine that turns sequencer-level transaction requests into Z80-style machine cycles: T-states, wait states, M1 fetch and refresh.
- Sits between the sequencer and the pins. Supersedes combinational strobe decoding by adding cycle timing, nWAIT handling, configurable wait states and width generalisation.

Parameters:
- ADDR_W, 16, address bus width
- DATA_W, 8, data bus width
- MEM_WAIT, 0, mandatory extra TW states on memory and fetch cycles (0-7)
- IO_WAIT, 1, additional mandatory TW states on I/O cycles, on top of MEM_WAIT (0-7)
- REFRESH_EN, 1, when 1, fetch cycles run T3/T4 refresh; when 0, fetch ends after T3 like a memory read

Ports:
- clk  in  1  single clock; one clk = one T-state
- reset  in  1  synchronous, active-high
- req  in  1  transaction request
- kind  in  3  0 MEM_RD, 1 MEM_WR, 2 IO_RD, 3 IO_WR, 4 FETCH; 5-7 illegal
- req_addr  in  ADDR_W  transaction address
- req_wdata  in  DATA_W  write data
- rfsh_addr  in  ADDR_W  refresh address ({I,R}) driven during T3/T4 of fetch
- ready  out  1  request accepted this cycle when req&&ready
- done  out  1  one-cycle pulse: transaction complete
- rdata  out  DATA_W  captured read data, valid while done
- nWAIT  in  1  active-low wait input
- READ_D  in  DATA_W  bus read data
- A  out  ADDR_W  address bus
- WRITE_D  out  DATA_W  write data
- bus_oe  out  1  WRITE_D drive enable
- nMREQ, nIORQ, nRD, nWR, nM1, nRFSH  out  1 each  active-low strobes

Behaviour:
- Reset (sync): state IDLE; all strobes high; A=0, WRITE_D=0, bus_oe=0, done=0, rdata=0, wait counter 0. Reset mid-cycle aborts it: strobes high on the next edge, no done.
- All pin outputs are registered. Values below are what is held during each T-state cycle.
- States: IDLE, T1, T2, TW, T3, T4.
- ready=1 in IDLE and in the final T-state (T3 for non-fetch; T4 for fetch when REFRESH_EN=1). Accept in the final T-state gives back-to-back T1 with no idle gap.
- On accept, latch kind/req_addr/req_wdata and go to T1. Load wait counter with MEM_WAIT, plus IO_WAIT for I/O kinds.
- Illegal kind with req: ignored. No state change, no done.
- T1: A=addr, all strobes high. nM1 low if FETCH. For writes, WRITE_D=wdata and bus_oe=1, held through T3.
- T2: MEM_RD/FETCH: nMREQ, nRD low. MEM_WR: nMREQ, nWR low. IO_RD: nIORQ, nRD low. IO_WR: nIORQ, nWR low. nM1 still low for FETCH.
- Exit T2/TW: if counter>0, go TW and decrement. Else if nWAIT==0 (sampled that edge), go TW. Else go T3. Strobes hold through TW.
- Non-fetch T3: strobes held low. READ_D captured into rdata at the edge ending T3. done=1 the following cycle. Strobes high after T3.
- FETCH: READ_D captured at the edge ending the last T2/TW.
  - REFRESH_EN=1: T3 has A=rfsh_addr, nRFSH low, nMREQ low, nRD/nM1 high. T4 has A=rfsh_addr, nRFSH low, nMREQ high. done=1 the cycle after T4.
  - REFRESH_EN=0: fetch ends after T3 like a memory read; nM1 is high in T3.
- Minimum lengths: memory 3 T, I/O 3+IO_WAIT T, fetch 4 T (MEM_WAIT=0, nWAIT high).
- Invariants: never nRD&&nWR both low; never nMREQ&&nIORQ both low; bus_oe only on write kinds; done never on two consecutive cycles without an intervening accept.
- Widths: all wait counting in 3 bits. Sum MEM_WAIT+IO_WAIT must be ≤7; elaboration-time assertion.

Decomposition:
- Package z80_bus_pkg:
  - bus_kind_t enum (MEM_RD..FETCH)
  - tstate_t enum (IDLE..T4)
  - strobe bundle struct
  - helpers is_io(kind), is_write(kind)
- One sub-module, z80_wait_ctr: loads the mandatory wait count, decrements, and combines with nWAIT to produce stay_in_tw. Everything else stays in z80_bus_cycle.

Test Plan:
- MEM_RD addr 0x1234, READ_D=0xA5, nWAIT=1, defaults → nMREQ/nRD low exactly 2 cycles (T2,T3); done one cycle later with rdata=0xA5; total 3 T.
- IO_WR addr 0x00FE, data 0x3C, IO_WAIT=1 → nIORQ/nWR low T2,TW,T3; WRITE_D=0x3C, bus_oe=1 for T1..T3; done after 4 T.
- FETCH addr 0x0100, READ_D=0xC3, rfsh_addr 0x7F05 → nM1 low T1-T2; rdata=0xC3; A=0x7F05 with nRFSH low in T3,T4; done after T4.
- MEM_RD with nWAIT low for 3 sampled edges → exactly 3 TW inserted; strobes held; data sampled only at end of T3.
- Back-to-back MEM_WR then MEM_RD with req held → second T1 immediately follows first T3; no idle cycle; invariants hold.
- Reset asserted during TW of an I/O read → all strobes high and state IDLE next cycle; no done; illegal kind 6 with req → ignored, no done.
